// File: rtl/shift_pkg.sv
// Shared definitions for the universal shift register family:
// op encodings, controller state encoding and op-width constant.
package shift_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_SHL = 3'b000;
    localparam logic [OP_W-1:0] OP_SHR = 3'b001;
    localparam logic [OP_W-1:0] OP_SRA = 3'b010;
    localparam logic [OP_W-1:0] OP_ROL = 3'b011;
    localparam logic [OP_W-1:0] OP_ROR = 3'b100;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    // Encodings above OP_ROR are reserved: the register and tap hold.
    function automatic logic op_is_valid(input logic [OP_W-1:0] o);
        return (o <= OP_ROR);
    endfunction

endpackage

// File: rtl/shift_step_unit.sv
// Single-step shift/rotate datapath: computes the next register value and
// the bit leaving the register for one step of the selected op.
module shift_step_unit
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] cur,
    input  logic [OP_W-1:0]  op,
    input  logic             sin,
    output logic [WIDTH-1:0] nxt,
    output logic             bit_out
);

    always_comb begin
        nxt     = cur;
        bit_out = 1'b0;
        case (op)
            OP_SHL: begin
                nxt     = {cur[WIDTH-2:0], sin};
                bit_out = cur[WIDTH-1];
            end
            OP_SHR: begin
                nxt     = {sin, cur[WIDTH-1:1]};
                bit_out = cur[0];
            end
            OP_SRA: begin
                nxt     = {cur[WIDTH-1], cur[WIDTH-1:1]};
                bit_out = cur[0];
            end
            OP_ROL: begin
                nxt     = {cur[WIDTH-2:0], cur[WIDTH-1]};
                bit_out = cur[WIDTH-1];
            end
            OP_ROR: begin
                nxt     = {cur[0], cur[WIDTH-1:1]};
                bit_out = cur[0];
            end
            default: begin
                nxt     = cur;
                bit_out = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multi_shift_register.sv
// Universal shift register with parallel load, quotient-bit write and
// counter-sequenced multi-bit shifts reported through a busy/done handshake.
module multi_shift_register
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [WIDTH-1:0] in,
    input  logic             start,
    input  logic [OP_W-1:0]  op,
    input  logic [CNT_W-1:0] amt,
    input  logic             sin,
    input  logic             qbit_wr,
    input  logic             qbit_val,
    output logic [WIDTH-1:0] out,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [OP_W-1:0]  op_q, op_n;
    logic [WIDTH-1:0] out_n;
    logic             sout_n, busy_n, done_n;
    logic [WIDTH-1:0] step_nxt;
    logic             step_bit;

    shift_step_unit #(
        .WIDTH (WIDTH)
    ) u_step (
        .cur     (out),
        .op      (op_q),
        .sin     (sin),
        .nxt     (step_nxt),
        .bit_out (step_bit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            op_q  <= OP_SHL;
            out   <= '0;
            sout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            op_q  <= op_n;
            out   <= out_n;
            sout  <= sout_n;
            busy  <= busy_n;
            done  <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        op_n    = op_q;
        out_n   = out;
        sout_n  = sout;
        busy_n  = busy;
        done_n  = 1'b0;
        case (state)
            S_IDLE: begin
                if (ld) begin
                    out_n = in;
                end else if (start) begin
                    if (amt != '0) begin
                        op_n    = op;
                        cnt_n   = amt;
                        busy_n  = 1'b1;
                        state_n = S_SHIFT;
                    end else begin
                        done_n = 1'b1;
                    end
                end else if (qbit_wr) begin
                    out_n[0] = qbit_val;
                end
            end
            S_SHIFT: begin
                // A load aborts the sequence silently; no done pulse.
                if (ld) begin
                    out_n   = in;
                    cnt_n   = '0;
                    busy_n  = 1'b0;
                    state_n = S_IDLE;
                end else begin
                    out_n = step_nxt;
                    if (op_is_valid(op_q)) begin
                        sout_n = step_bit;
                    end
                    cnt_n = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        state_n = S_IDLE;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_multi_shift_register.sv
// Bench for multi_shift_register: table of load/shift vectors checked via a
// scoreboard at done, plus hand-written qbit, abort and async-reset sequences.
module tb_multi_shift_register;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             ld, start, sin, qbit_wr, qbit_val;
    logic [WIDTH-1:0] in;
    logic [2:0]       op;
    logic [CNT_W-1:0] amt;
    logic [WIDTH-1:0] out;
    logic             sout, busy, done;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [WIDTH-1:0] ld_val;
        logic [2:0]       op;
        logic [CNT_W-1:0] amt;
        logic             sin;
        logic [WIDTH-1:0] exp_out;
        logic             exp_sout;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] exp_out;
        logic             exp_sout;
        int               exp_busy;
    } sb_t;

    vec_t vecs[8];
    sb_t  sb[$];

    multi_shift_register #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ld       (ld),
        .in       (in),
        .start    (start),
        .op       (op),
        .amt      (amt),
        .sin      (sin),
        .qbit_wr  (qbit_wr),
        .qbit_val (qbit_val),
        .out      (out),
        .sout     (sout),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic do_load(input logic [WIDTH-1:0] v);
        ld = 1'b1;
        in = v;
        tick();
        ld = 1'b0;
    endtask

    // Start a sequence, push its expectation, wait (bounded) for done and compare.
    task automatic run_shift(input string nm, input logic [2:0] o, input logic [CNT_W-1:0] a,
                             input logic s, input logic [WIDTH-1:0] eo, input logic es);
        sb_t e;
        int  bc;
        bit  got;
        sb.push_back('{eo, es, int'(a)});
        op    = o;
        amt   = a;
        sin   = s;
        start = 1'b1;
        tick();
        start = 1'b0;
        bc  = 0;
        got = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy) bc++;
            tick();
        end
        e = sb.pop_front();
        if (!got) begin
            check({nm, " done timeout"}, 32'd0, 32'd1);
        end else begin
            check({nm, " out"}, out, e.exp_out);
            check({nm, " sout"}, sout, e.exp_sout);
            check({nm, " busy cycles"}, bc, e.exp_busy);
            tick();
            check({nm, " done single pulse"}, done, 1'b0);
        end
    endtask

    initial begin
        vecs[0] = '{8'hA5, 3'b000, 4'd3,  1'b0, 8'h28, 1'b1};
        vecs[1] = '{8'h3C, 3'b111, 4'd2,  1'b0, 8'h3C, 1'b1};
        vecs[2] = '{8'h3C, 3'b011, 4'd8,  1'b0, 8'h3C, 1'b0};
        vecs[3] = '{8'h90, 3'b010, 4'd2,  1'b0, 8'hE4, 1'b0};
        vecs[4] = '{8'h81, 3'b100, 4'd1,  1'b0, 8'hC0, 1'b1};
        vecs[5] = '{8'h0F, 3'b001, 4'd2,  1'b1, 8'hC3, 1'b1};
        vecs[6] = '{8'h81, 3'b011, 4'd3,  1'b0, 8'h0C, 1'b0};
        vecs[7] = '{8'hFF, 3'b000, 4'd15, 1'b1, 8'hFF, 1'b1};

        ld = 0; in = '0; start = 0; op = '0; amt = '0; sin = 0; qbit_wr = 0; qbit_val = 0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        check("reset out", out, 8'h00);
        check("reset sout", sout, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            do_load(vecs[i].ld_val);
            check($sformatf("vec%0d load", i), out, vecs[i].ld_val);
            run_shift($sformatf("vec%0d", i), vecs[i].op, vecs[i].amt, vecs[i].sin,
                      vecs[i].exp_out, vecs[i].exp_sout);
        end

        // Quotient-bit write in idle, then ignored while busy.
        do_load(8'h40);
        qbit_wr = 1'b1; qbit_val = 1'b1;
        tick();
        qbit_wr = 1'b0;
        check("qbit write", out, 8'h41);
        op = 3'b111; amt = 4'd2; start = 1'b1;
        tick();
        start = 1'b0;
        qbit_wr = 1'b1; qbit_val = 1'b0;
        tick();
        tick();
        qbit_wr = 1'b0;
        check("qbit busy done", done, 1'b1);
        check("qbit busy ignored", out, 8'h41);

        // start with amt=0 and a simultaneous qbit write: done only, qbit dropped.
        op = 3'b000; amt = 4'd0; start = 1'b1; qbit_wr = 1'b1; qbit_val = 1'b0;
        tick();
        start = 1'b0; qbit_wr = 1'b0;
        check("amt0 done", done, 1'b1);
        check("amt0 busy", busy, 1'b0);
        check("amt0 qbit dropped", out, 8'h41);
        tick();
        check("amt0 done pulse", done, 1'b0);

        // Load on the second busy cycle aborts without done.
        do_load(8'h80);
        op = 3'b000; amt = 4'd5; sin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        ld = 1'b1; in = 8'h11;
        tick();
        ld = 1'b0;
        begin
            bit saw_done;
            check("abort out", out, 8'h11);
            check("abort busy", busy, 1'b0);
            saw_done = done;
            for (int c = 0; c < 6; c++) begin
                tick();
                saw_done |= done;
            end
            check("abort no done", saw_done, 1'b0);
            check("abort out held", out, 8'h11);
        end

        // Asynchronous reset between edges in the middle of a sequence.
        do_load(8'hFF);
        op = 3'b000; amt = 4'd5; sin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("pre-reset sout", sout, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("async rst out", out, 8'h00);
        check("async rst busy", busy, 1'b0);
        check("async rst sout", sout, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("post-reset idle", busy, 1'b0);
        do_load(8'h01);
        run_shift("post-reset shl", 3'b000, 4'd1, 1'b0, 8'h02, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/multi_shift_register.md
Name: multi_shift_register

Overview:
- Parametrised universal shift register for divider and multiplier datapaths (restoring divider remainder/quotient, future multipliers).
- Adds parallel load, five shift/rotate modes and multi-bit shifts sequenced by an internal counter with busy/done handshake.
- Adds a serial-out tap and a quotient-bit LSB write.
- One bit moves per clock; the controlling FSM only issues start/ld and waits for done.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- CNT_W, 4, width of shift-amount input; max shift = 2^CNT_W-1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- ld  input  1  parallel load of in.
- in  input  WIDTH  parallel load data.
- start  input  1  begin multi-bit shift (single-cycle pulse).
- op  input  3  shift mode, sampled with start.
- amt  input  CNT_W  number of single-bit steps, sampled with start.
- sin  input  1  serial input; sampled live on every shift step.
- qbit_wr  input  1  write qbit_val into out[0].
- qbit_val  input  1  quotient bit value.
- out  output  WIDTH  register contents.
- sout  output  1  last bit shifted/rotated out.
- busy  output  1  shift sequence in progress.
- done  output  1  one-cycle pulse at sequence end.

Behaviour:
- Reset (rst=0, asynchronous, no clock needed): out=0, sout=0, busy=0, done=0, counter=0, FSM=IDLE. Applies immediately, including mid-sequence.
- Op encoding:
  - 000 SHL: out<= {out[W-2:0],sin}, sout<=out[W-1].
  - 001 SHR: {sin,out[W-1:1]}, sout<=out[0].
  - 010 SRA: {out[W-1],out[W-1:1]}, sout<=out[0].
  - 011 ROL: {out[W-2:0],out[W-1]}, sout<=out[W-1].
  - 100 ROR: {out[0],out[W-1:1]}, sout<=out[0].
  - 101-111 reserved: out and sout hold; counting and handshake proceed normally.
- FSM states IDLE, SHIFT. done is a registered output, default 0 every cycle.
- IDLE priority ld > start > qbit_wr:
  - ld: out<=in; sout holds.
  - start with amt!=0: latch op, counter<=amt, busy<=1 → SHIFT; no shift on this edge.
  - start with amt==0: done<=1 next cycle, out unchanged, busy stays 0.
  - qbit_wr: out[0]<=qbit_val, other bits hold.
- SHIFT, each edge: perform one step per latched op, counter<=counter-1.
  - On the step where counter==1: busy<=0, done<=1, →IDLE.
  - Latency: amt=N gives busy high N cycles, N shifts at edges E1..EN after start edge E0; done is high the cycle after EN.
- ld during SHIFT: out<=in, abort; busy<=0, →IDLE, done not asserted.
- start and qbit_wr during SHIFT: ignored, no queuing.
- Amounts >= WIDTH are legal; rotates wrap modulo WIDTH by construction.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package shift_pkg holds:
  - op localparams OP_SHL, OP_SHR, OP_SRA, OP_ROL, OP_ROR;
  - FSM state encodings S_IDLE, S_SHIFT;
  - OP_W=3.
- One combinational sub-module, shift_step_unit(WIDTH): inputs cur, op, sin; outputs nxt, bit_out. It computes one step and is reused by future barrel variants.
- Counter and FSM stay in the top.

Test Plan:
- WIDTH=8. ld in=0xA5; start op=SHL amt=3 sin=0 → busy 3 cycles; out=0x28, sout=1, done pulse exactly one cycle.
- ld 0x90; start op=SRA amt=2 → out=0xE4, sout=0. Then op=ROR amt=1 on 0x81 → out=0xC0, sout=1.
- ld 0x3C; op=ROL amt=8 → busy 8 cycles, out=0x3C, done once. Then op=111 amt=2 → out unchanged, done after 2 busy cycles.
- ld 0x40; qbit_wr=1 qbit_val=1 → out=0x41. Repeat qbit_wr during busy → ignored. start and qbit_wr in the same idle cycle → qbit dropped.
- SHL amt=5 started; ld in=0x11 on the 2nd busy cycle → out=0x11, busy=0 next cycle, no done. start amt=0 → done next cycle, out unchanged.
- Mid-SHIFT, drop rst between clock edges → out=0, busy=0, sout=0 immediately. Release, then normal SHL amt=1 on loaded 0x01 → 0x02.
